// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//
// Consumer side of a fifo_v3 (FALL_THROUGH=0). On a software start it pops a
// burst of len_i entries one at a time and forwards each on a valid/ready
// output stream. It also accumulates per-burst statistics: count, sum and
// minimum. Only one burst is in flight at a time, and a one-cycle done_o
// pulse marks its end.
//
// Optional feature: define FIFO_BURST_READER_TIMEOUT_EN to abort a burst after
// TIMEOUT_CYCLES consecutive empty cycles while waiting for data (timeout_o
// reports the abort). Without the macro the block waits for data indefinitely
// and timeout_o is tied low.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   start_i       start a burst (sampled only when idle)
//   len_i         burst length, captured with an accepted start
//   busy_o        burst in progress (fetching or sending)
//   done_o        one-cycle pulse at burst end
//   fifo_empty_i  FIFO empty flag
//   fifo_data_i   FIFO head data, valid while not empty
//   fifo_pop_o    FIFO pop, one cycle per entry (combinational)
//   out_valid_o   output stream valid
//   out_ready_i   output stream ready
//   out_data_o    output stream data
//   count_o       entries transferred in the current/last burst
//   sum_o         sum of transferred entries (wide enough to never overflow)
//   min_o         minimum transferred entry (all ones when none)
//   timeout_o     last burst aborted by timeout

module fifo_burst_reader #(
    parameter int DATA_WIDTH     = 8,
    parameter int LEN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [LEN_WIDTH-1:0]            len_i,
    output logic                            busy_o,
    output logic                            done_o,
    input  logic                            fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]           fifo_data_i,
    output logic                            fifo_pop_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    output logic [LEN_WIDTH-1:0]            count_o,
    output logic [DATA_WIDTH+LEN_WIDTH-1:0] sum_o,
    output logic [DATA_WIDTH-1:0]           min_o,
    output logic                            timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                          state_r;
    logic [LEN_WIDTH-1:0]            len_r;
    logic [LEN_WIDTH-1:0]            count_next_s;
    logic [DATA_WIDTH+LEN_WIDTH-1:0] sum_next_s;
    logic [DATA_WIDTH-1:0]           min_next_s;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             timeout_r;

    assign timeout_o = timeout_r;
`else
    assign timeout_o = 1'b0;
`endif

    // The pop is combinational so the FIFO advances in the same cycle the head
    // is captured; reset and an empty FIFO both suppress it.
    assign fifo_pop_o = (state_r == FETCH) && !fifo_empty_i && !rst_i;

    // Statistics after accepting the entry currently held on the output stream
    always_comb begin
        count_next_s = count_o + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
        sum_next_s   = sum_o + {{LEN_WIDTH{1'b0}}, out_data_o};
        if (out_data_o < min_o) begin
            min_next_s = out_data_o;
        end else begin
            min_next_s = min_o;
        end
    end

    // Burst sequencer: state, registered stream/status outputs and statistics
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            len_r       <= {LEN_WIDTH{1'b0}};
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= {DATA_WIDTH{1'b0}};
            count_o     <= {LEN_WIDTH{1'b0}};
            sum_o       <= {(DATA_WIDTH+LEN_WIDTH){1'b0}};
            min_o       <= {DATA_WIDTH{1'b1}};
`ifdef FIFO_BURST_READER_TIMEOUT_EN
            tmo_cnt_r   <= {TMO_W{1'b0}};
            timeout_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        len_r   <= len_i;
                        count_o <= {LEN_WIDTH{1'b0}};
                        sum_o   <= {(DATA_WIDTH+LEN_WIDTH){1'b0}};
                        min_o   <= {DATA_WIDTH{1'b1}};
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                        timeout_r <= 1'b0;
                        tmo_cnt_r <= {TMO_W{1'b0}};
`endif
                        // A zero-length burst completes without touching the FIFO.
                        if (len_i != {LEN_WIDTH{1'b0}}) begin
                            state_r <= FETCH;
                            busy_o  <= 1'b1;
                        end else begin
                            state_r <= DONE;
                            done_o  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end

                FETCH: begin
                    if (!fifo_empty_i) begin
                        out_data_o  <= fifo_data_i;
                        out_valid_o <= 1'b1;
                        state_r     <= SEND;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                        tmo_cnt_r   <= {TMO_W{1'b0}};
`endif
                    end else begin
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                        // Give up once the FIFO has stayed empty for the full limit;
                        // the statistics keep whatever was already transferred.
                        if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                            state_r   <= DONE;
                            busy_o    <= 1'b0;
                            done_o    <= 1'b1;
                            timeout_r <= 1'b1;
                            tmo_cnt_r <= {TMO_W{1'b0}};
                        end else begin
                            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                        end
`else
                        state_r <= FETCH;
`endif
                    end
                end

                SEND: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        count_o     <= count_next_s;
                        sum_o       <= sum_next_s;
                        min_o       <= min_next_s;
                        if (count_next_s == len_r) begin
                            state_r <= DONE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            state_r <= FETCH;
                        end
                    end else begin
                        state_r <= SEND;
                    end
                end

                DONE: begin
                    done_o  <= 1'b0;
                    state_r <= IDLE;
                end

                default: begin
                    state_r     <= IDLE;
                    busy_o      <= 1'b0;
                    done_o      <= 1'b0;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader (default parameters 8/4/16).
// The FIFO is modelled as an array with head/tail pointers. The output stream
// must reproduce the pushed data in order. Each burst's statistics are computed
// from its planned data when the burst is issued. A monitor on the falling edge
// pops the expected values and compares them.
module tb_fifo_burst_reader;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        start     = 1'b0;
    logic [3:0]  len       = 4'd0;
    logic        out_ready = 1'b1;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_pop;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [3:0]  count;
    logic [11:0] sum;
    logic [7:0]  min_v;
    logic        timeout;
    logic        busy;
    logic        done;

    fifo_burst_reader dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .len_i        (len),
        .busy_o       (busy),
        .done_o       (done),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_pop_o   (fifo_pop),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .count_o      (count),
        .sum_o        (sum),
        .min_o        (min_v),
        .timeout_o    (timeout)
    );

    initial forever #5 clk = ~clk;

    // FIFO model (registered output, no fall-through)
    logic [7:0] mem [0:1023];
    int head = 0;
    int tail = 0;
    assign fifo_empty = (head == tail);
    assign fifo_data  = mem[head % 1024];
    always @(posedge clk) if (fifo_pop && head != tail) head <= head + 1;

    typedef struct {int cnt; int sum; int mn; bit tmo;} stats_t;
    logic [7:0] exp_q[$];
    stats_t     st_q[$];
    logic [7:0] plan_q[$];

    int vectors = 0;
    int errors  = 0;
    int hs_cnt = 0, done_cnt = 0, burst_pops = 0;
    bit prev_done = 1'b0, prev_rst = 1'b0, hold_v = 1'b0;
    logic [7:0] hold_d;
    stats_t mon_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: compares everything the DUT presents against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (!fifo_empty) chk("pop_in_reset", fifo_pop, 0);
            hold_v = 1'b0;
            prev_done = 1'b0;
            burst_pops = 0;
        end else begin
            if (prev_rst)
                chk("reset_state", {busy, done, fifo_pop, out_valid, timeout, out_data, count, sum, min_v},
                    {5'b0, 8'h00, 4'h0, 12'h000, 8'hFF});
            if (fifo_pop) begin
                chk("pop_nonempty", fifo_empty, 0);
                burst_pops++;
            end
            if (hold_v && out_valid) chk("data_hold", out_data, hold_d);
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
                else chk("out_data", out_data, exp_q.pop_front());
                hs_cnt++;
            end
            if (done) begin
                chk("done_pulse", prev_done, 0);
                if (st_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    mon_s = st_q.pop_front();
                    chk("count", count, mon_s.cnt);
                    chk("sum", sum, mon_s.sum);
                    chk("min", min_v, mon_s.mn);
                    chk("timeout", timeout, mon_s.tmo);
                    chk("pops_per_burst", burst_pops, mon_s.cnt);
                end
                burst_pops = 0;
                done_cnt++;
            end
            prev_done = done;
        end
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [7:0] v);
        mem[tail % 1024] = v;
        tail = tail + 1;
    endtask

    // Issue one burst using the first l entries of plan_q
    task automatic run_burst(input int l, input int prefill, input bit rnd_ready,
                             input bit stall2, input bit skip_push);
        stats_t s;
        logic [7:0] pend[$];
        int d0, hs0, c, stall_n, pf;
        s.cnt = l; s.sum = 0; s.mn = 255; s.tmo = 1'b0;
        for (int i = 0; i < l; i++) begin
            s.sum += int'(plan_q[i]);
            if (int'(plan_q[i]) < s.mn) s.mn = int'(plan_q[i]);
            if (!skip_push) begin
                exp_q.push_back(plan_q[i]);
                pend.push_back(plan_q[i]);
            end
        end
        plan_q.delete();
        st_q.push_back(s);
        pf = prefill;
        while (pend.size() > 0 && pf > 0) begin
            push_entry(pend.pop_front());
            pf--;
        end
        hs0 = hs_cnt; d0 = done_cnt;
        start = 1'b1; len = 4'(l);
        tick();
        start = 1'b0; len = 4'($urandom);
        c = 0; stall_n = 0;
        while (done_cnt == d0 && c < 400) begin
            if (pend.size() > 0 && $urandom_range(0, 2) == 0) push_entry(pend.pop_front());
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall2 && hs_cnt - hs0 == 1 && out_valid && stall_n < 4) begin
                out_ready = 1'b0;
                stall_n++;
            end
            // start while busy must be ignored
            if ($urandom_range(0, 7) == 0) begin start = 1'b1; len = 4'($urandom); end
            else start = 1'b0;
            tick();
            c++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("burst_finished", done_cnt - d0, 1);
        chk("fifo_drained", tail - head, 0);
        if (l == 0) chk("len0_latency", (c <= 2), 1);
        if (stall2) chk("stall_applied", stall_n, 4);
    endtask

    initial begin
        int d0, hs0, c;
        logic [7:0] v1, v2;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // basic burst and the same burst with a stalled second entry
        plan_q = '{8'd5, 8'd3, 8'd9};
        run_burst(3, 3, 1'b0, 1'b0, 1'b0);
        plan_q = '{8'd5, 8'd3, 8'd9};
        run_burst(3, 3, 1'b0, 1'b1, 1'b0);
        // zero-length burst
        run_burst(0, 0, 1'b0, 1'b0, 1'b0);
        // maximum length, all ones: sum 3825 without wrap
        repeat (15) plan_q.push_back(8'hFF);
        run_burst(15, 15, 1'b0, 1'b0, 1'b0);

        // random bursts: random data, length, FIFO fill timing and backpressure
        for (int b = 0; b < 25; b++) begin
            int l;
            l = $urandom_range(0, 15);
            repeat (l) plan_q.push_back(8'($urandom));
            run_burst(l, $urandom_range(0, l), 1'b1, 1'b0, 1'b0);
        end

        // reset in SEND after 2 of 4 entries; the popped third entry is lost
        for (int i = 0; i < 4; i++) begin
            v1 = 8'($urandom);
            exp_q.push_back(v1);
            push_entry(v1);
        end
        v2 = v1;
        hs0 = hs_cnt; d0 = done_cnt;
        start = 1'b1; len = 4'd4;
        tick();
        c = 0;
        while (hs_cnt - hs0 < 2 && c < 50) begin
            start = 1'b1; len = 4'hF;
            tick();
            c++;
        end
        start = 1'b0;
        chk("reset_test_progress", hs_cnt - hs0, 2);
        out_ready = 1'b0;
        tick();
        chk("send_before_reset", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        void'(exp_q.pop_front());
        chk("no_done_on_abort", done_cnt - d0, 0);
        tick();
        plan_q = '{v2};
        run_burst(1, 0, 1'b0, 1'b0, 1'b1);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
        st_q.push_back('{0, 0, 255, 1'b1});
        d0 = done_cnt;
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0;
        c = 0;
        while (done_cnt == d0 && c < 60) begin
            tick();
            c++;
        end
        chk("timeout_latency", (c >= 16 && c <= 18), 1);
        tick();
        tick();
        chk("timeout_hold", timeout, 1);
        chk("timeout_idle", busy, 0);
`else
        d0 = done_cnt;
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0;
        repeat (100) tick();
        chk("no_timeout_busy", busy, 1);
        chk("no_timeout_flag", timeout, 0);
        chk("no_timeout_done", done_cnt - d0, 0);
        v1 = 8'($urandom);
        v2 = 8'($urandom);
        st_q.push_back('{2, int'(v1) + int'(v2), (v1 < v2) ? int'(v1) : int'(v2), 1'b0});
        exp_q.push_back(v1);
        exp_q.push_back(v2);
        push_entry(v1);
        push_entry(v2);
        c = 0;
        while (done_cnt == d0 && c < 50) begin
            tick();
            c++;
        end
        chk("late_data_burst_done", done_cnt - d0, 1);
`endif

        repeat (3) tick();
        chk("outputs_left", exp_q.size(), 0);
        chk("stats_left", st_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
